// File: rtl/io_bank_responder.sv
// rtl/io_bank_responder.sv - memory-mapped I/O bank: ms counter, cycle timer with irq, keyboard FIFO, LEDs
// Reads are combinational from addr; writes and FIFO pops commit on the next posedge.
module io_bank_responder #(
  parameter int CLKS_PER_MS = 50000,
  parameter int FIFO_DEPTH  = 8,
  parameter int LED_WIDTH   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic [3:0]           memWrite,
  input  logic [10:0]          addr,
  input  logic [31:0]          wdata,
  output logic [31:0]          rdata,
  input  logic                 key_valid,
  input  logic [7:0]           key_code,
  output logic [LED_WIDTH-1:0] leds,
  output logic                 irq
);

  localparam int PW = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  localparam logic [PW-1:0] PRESC_MAX = PW'(CLKS_PER_MS - 1);
  localparam logic [PW-1:0] PRESC_ONE = PW'(1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_FULL  = CW'(FIFO_DEPTH);

  localparam logic [10:0] A_MS     = 11'h000;
  localparam logic [10:0] A_LOAD   = 11'h001;
  localparam logic [10:0] A_CTRL   = 11'h002;
  localparam logic [10:0] A_STAT   = 11'h003;
  localparam logic [10:0] A_KSTAT  = 11'h004;
  localparam logic [10:0] A_KDATA  = 11'h005;
  localparam logic [10:0] A_LEDS   = 11'h006;
  localparam logic [10:0] A_TCOUNT = 11'h007;

  logic [PW-1:0]        r_presc;
  logic [31:0]          r_ms;
  logic [31:0]          r_load;
  logic [31:0]          r_tcount;
  logic [2:0]           r_ctrl;
  logic                 r_expired;
  logic                 r_irq;
  logic [7:0]           r_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_wptr;
  logic [AW-1:0]        r_rptr;
  logic [CW-1:0]        r_count;
  logic                 r_ovf;
  logic [LED_WIDTH-1:0] r_leds;

  logic                 w_rd;
  logic                 w_wr;
  logic [31:0]          w_mask;
  logic [31:0]          w_load_next;
  logic [LED_WIDTH-1:0] w_leds_next;
  logic                 w_tick;
  logic                 w_expire;
  logic                 w_w1c_exp;
  logic                 w_w1c_ovf;
  logic                 w_empty;
  logic                 w_full;
  logic                 w_pop;
  logic                 w_push;
  logic                 w_drop;

  assign w_rd   = en & (memWrite == 4'b0000);
  assign w_wr   = en & (memWrite != 4'b0000);
  assign w_mask = {{8{memWrite[3]}}, {8{memWrite[2]}}, {8{memWrite[1]}}, {8{memWrite[0]}}};

  // Byte-lane merge: unstrobed bytes keep their current value.
  assign w_load_next = (wdata & w_mask) | (r_load & ~w_mask);
  assign w_leds_next = (wdata[LED_WIDTH-1:0] & w_mask[LED_WIDTH-1:0]) |
                       (r_leds & ~w_mask[LED_WIDTH-1:0]);

  assign w_tick    = r_ctrl[0] & (r_tcount != 32'd0);
  assign w_expire  = r_ctrl[0] & (r_tcount == 32'd1);
  assign w_w1c_exp = w_wr & (addr == A_STAT) & memWrite[0] & wdata[0];
  assign w_w1c_ovf = w_wr & (addr == A_KSTAT) & memWrite[0] & wdata[2];

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CNT_FULL);
  assign w_pop   = w_rd & (addr == A_KDATA) & ~w_empty;
  // A full FIFO still accepts a push when the same cycle pops the head.
  assign w_push  = key_valid & (~w_full | w_pop);
  assign w_drop  = key_valid & w_full & ~w_pop;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_presc <= '0;
      r_ms    <= '0;
    end else if (r_presc == PRESC_MAX) begin
      r_presc <= '0;
      r_ms    <= r_ms + 32'd1;
    end else begin
      r_presc <= r_presc + PRESC_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_load    <= '0;
      r_tcount  <= '0;
      r_ctrl    <= '0;
      r_expired <= 1'b0;
      r_irq     <= 1'b0;
    end else begin
      if (w_wr & (addr == A_LOAD)) begin
        r_load   <= w_load_next;
        r_tcount <= w_load_next;
      end else if (w_expire) begin
        r_tcount <= r_ctrl[1] ? r_load : 32'd0;
      end else if (w_tick) begin
        r_tcount <= r_tcount - 32'd1;
      end
      if (w_wr & (addr == A_CTRL) & memWrite[0])
        r_ctrl <= wdata[2:0];
      if (w_expire)
        r_expired <= 1'b1;
      else if (w_w1c_exp)
        r_expired <= 1'b0;
      r_irq <= r_expired & r_ctrl[2];
    end
  end

  // Storage needs no reset: pointers and count gate every read of it.
  always_ff @(posedge clk) begin
    if (!reset && w_push)
      r_mem[r_wptr] <= key_code;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_ONE;
      if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
      if (w_drop)
        r_ovf <= 1'b1;
      else if (w_w1c_ovf)
        r_ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      r_leds <= '0;
    else if (w_wr & (addr == A_LEDS))
      r_leds <= w_leds_next;
  end

  always_comb begin
    rdata = 32'd0;
    if (w_rd) begin
      case (addr)
        A_MS:     rdata = r_ms;
        A_LOAD:   rdata = r_load;
        A_CTRL:   rdata = {29'd0, r_ctrl};
        A_STAT:   rdata = {31'd0, r_expired};
        A_KSTAT:  rdata = (32'(r_count) << 8) | {29'd0, r_ovf, w_full, ~w_empty};
        A_KDATA:  rdata = w_empty ? 32'd0 : {24'd0, r_mem[r_rptr]};
        A_LEDS:   rdata = 32'(r_leds);
        A_TCOUNT: rdata = r_tcount;
        default:  rdata = 32'd0;
      endcase
    end
  end

  assign leds = r_leds;
  assign irq  = r_irq;

endmodule

// File: doc/io_bank_responder.md
Name: io_bank_responder

Overview:
- Memory-mapped I/O bank that answers CPU accesses decoded to memory bank 2 (I/O). It replaces the constant-zero read path for that bank.
- Uses the same bus as the data memory: enable, per-byte write strobes, word address, write data and read data.
- Contains three resources:
  - a free-running millisecond counter;
  - a programmable cycle timer with interrupt;
  - an 8-bit keyboard scancode FIFO fed from an external source.
- Also drives a bank of LED outputs.

Parameters:
- CLKS_PER_MS, 50000: clk cycles per millisecond tick (>=2).
- FIFO_DEPTH, 8: keyboard FIFO entries (power of two, 2..256).
- LED_WIDTH, 8: LED output width (1..32).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- en  in  1  bank select, asserted for both reads and writes to this bank.
- memWrite  in  4  byte write strobes; bit i writes wdata[8i+7:8i]; 0 means read.
- addr  in  11  word address within the bank.
- wdata  in  32  write data, already lane-aligned by the write encoder.
- rdata  out  32  read data.
- key_valid  in  1  one-cycle scancode strobe.
- key_code  in  8  scancode, valid with key_valid.
- leds  out  LED_WIDTH  LED register.
- irq  out  1  timer interrupt.

Behaviour:
- Clock and reset: clk is the clock; reset is synchronous, active-high.
- Reset state: all registers 0, FIFO empty, prescaler 0. Resulting outputs: leds=0, irq=0; rdata is 0 unless en=1 and a readable register is addressed.
- Access rules:
  - Read: en=1 and memWrite=0. rdata is combinational from addr in the same cycle (zero latency, single-cycle CPU).
  - When en=0, rdata=0.
  - Unmapped read returns 0. Unmapped write is ignored.
  - Write: en=1 and memWrite!=0. Takes effect at the next posedge. Only strobed bytes of RW fields change.
- Register map (word address: name, access):
  - 0x000 MS_COUNT, RO: milliseconds since reset. The prescaler counts 0..CLKS_PER_MS-1; on the wrap cycle MS_COUNT increments, wrapping at 2^32.
  - 0x001 TIMER_LOAD, RW, 32 bits. A write also loads TIMER_COUNT with the new full LOAD value, taking effect the cycle after the write.
  - 0x002 TIMER_CTRL, RW: bit0 enable, bit1 auto-reload, bit2 irq enable; other bits read 0.
  - 0x003 TIMER_STATUS, W1C: bit0 expired.
  - 0x004 KEY_STATUS:
    - bit0 not-empty (RO).
    - bit1 full (RO).
    - bit2 overflow, sticky, W1C.
    - bits[15:8] entry count (RO).
  - 0x005 KEY_DATA, RO with pop: {24'd0, head}. Returns 0 when empty.
  - 0x006 LEDS, RW: low LED_WIDTH bits.
  - 0x007 TIMER_COUNT, RO.
- Timer (counts clk cycles):
  - Runs only when enable=1 and TIMER_COUNT!=0; it then decrements each cycle.
  - On a cycle where TIMER_COUNT==1 and enable=1: expired<=1. TIMER_COUNT <= auto-reload ? TIMER_LOAD : 0.
  - TIMER_COUNT==0 with enable=1: holds at 0, no expiry.
  - A TIMER_LOAD write in the same cycle as a decrement or reload: the write wins.
  - W1C of expired in the same cycle as a new expiry: the set wins.
  - irq = expired & irq enable. Registered, so it is asserted the cycle after expired is set.
- FIFO:
  - Push: key_valid=1 and not full, or full with a simultaneous pop.
  - Dropped push: key_valid while full without a pop. The code is discarded and overflow<=1. Overflow clear and a new overflow in the same cycle: the set wins.
  - Pop: a KEY_DATA read (en=1, memWrite=0, addr=0x005) when not empty. Read pointer advances at the posedge ending the read cycle. rdata in that cycle shows the pre-pop head.
  - Read of KEY_DATA when empty: returns 0, no pointer change.
  - Empty with push and pop in the same cycle: the read returns 0 and the push is accepted.
  - Pointers wrap modulo FIFO_DEPTH. Count ranges 0..FIFO_DEPTH.
- Writes to RO fields are ignored. A write to KEY_DATA does not pop.
- Reset asserted mid-operation: all state cleared on that edge, FIFO contents discarded.

Test Plan (CLKS_PER_MS=4, FIFO_DEPTH=4):
- Release reset, idle 13 cycles, read 0x000 -> 3. Read 0x001, 0x007, 0x010 -> 0. leds=0, irq=0.
- Write LOAD=3 (memWrite=4'hF), then CTRL=4'b0101 -> TIMER_COUNT reads 3,2,1,0. expired=1 on the cycle after count reads 1, irq=1 one cycle later. W1C 0x003 with wdata=1 -> irq=0, count stays 0.
- CTRL=4'b0111, LOAD=2 -> expired every 2 cycles, TIMER_COUNT alternates 2,1. W1C on an expiry cycle -> expired stays 1.
- Push 0x1C, 0x32, 0x21, 0x23, then 0x24 -> KEY_STATUS=0x0000_0407 (count 4, overflow, full, not-empty). Successive KEY_DATA reads return 0x1C, 0x32, 0x21, 0x23, then 0. Write 0x004 wdata=4 -> bit2=0.
- Full FIFO with key_valid(0x55) and a KEY_DATA read in the same cycle -> read returns oldest entry, count stays 4, no overflow, 0x55 is last out.
- LEDS=0 then write wdata=0xFFFF_FFA5 with memWrite=4'b0010 -> leds unchanged (byte 0 not strobed). memWrite=4'b0001 -> leds=0xA5. Assert reset mid-timer-countdown -> all registers and outputs 0 next cycle.
